// File: rtl/seg_capture.sv
// Seven-segment display snooper: recovers per-digit hex values from a scanned, active-low LED bus.
// Latency: an input change is reflected on the digit outputs 2+STABLE_CYCLES edges later; frame_done follows one edge after.
// Backpressure: none; this is a passive observer that never stalls, and glitches shorter than the stable window are dropped.
//
// Ports:
//   clk, rst_n               : clock and synchronous active-low reset
//   an_n[7:0]                : digit anodes (active-low, bit k = digit k)
//   seg_n[6:0], dp_n         : segment a..g and decimal-point cathodes (active-low)
//   digits[31:0]             : decoded nibble per digit, digit k at [4k+3:4k]
//   dp_out, digit_valid,
//   bad_pattern [7:0]        : per-digit status from that digit's last capture
//   frame_done               : one-cycle pulse once every digit has been captured
//   multi_anode_err          : sticky flag for a stable sample with several anodes low
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  an_n,
    input  logic [6:0]  seg_n,
    input  logic        dp_n,
    output logic [31:0] digits,
    output logic [7:0]  dp_out,
    output logic [7:0]  digit_valid,
    output logic [7:0]  bad_pattern,
    output logic        frame_done,
    output logic        multi_anode_err
);

    typedef enum logic [1:0] {SETTLE, CAPTURE, HELD} state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] sync1_q, sync2_q, prev_q;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  valid_q, valid_d;
    logic [7:0]  bad_q, bad_d;
    logic [7:0]  seen_q, seen_d;
    logic        frame_q, frame_d;
    logic        multi_q, multi_d;
    logic        do_cap;

    // Active-high views of the synchronized sample {an_n, dp_n, seg_n}.
    logic        sample_chg;
    logic [7:0]  an_act;
    logic [6:0]  seg_act;
    logic        dp_lit;
    logic [4:0]  dec;

    assign sample_chg = (sync2_q != prev_q);
    assign an_act     = ~sync2_q[15:8];
    assign dp_lit     = ~sync2_q[7];
    assign seg_act    = ~sync2_q[6:0];

    // Returns {hit, value}; lit segments ordered gfedcba.
    function automatic logic [4:0] hex_decode(input logic [6:0] s);
        case (s)
            7'h3F: return {1'b1, 4'h0};
            7'h06: return {1'b1, 4'h1};
            7'h5B: return {1'b1, 4'h2};
            7'h4F: return {1'b1, 4'h3};
            7'h66: return {1'b1, 4'h4};
            7'h6D: return {1'b1, 4'h5};
            7'h7D: return {1'b1, 4'h6};
            7'h07: return {1'b1, 4'h7};
            7'h7F: return {1'b1, 4'h8};
            7'h6F: return {1'b1, 4'h9};
            7'h77: return {1'b1, 4'hA};
            7'h7C: return {1'b1, 4'hB};
            7'h39: return {1'b1, 4'hC};
            7'h5E: return {1'b1, 4'hD};
            7'h79: return {1'b1, 4'hE};
            7'h71: return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    assign dec = hex_decode(seg_act);

    // Synchronizer and previous-sample register idle at all-ones (display dark).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= {an_n, dp_n, seg_n};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // The digit fields load on the edge that enters CAPTURE (counter reaching
    // STABLE_CYCLES-1); the CAPTURE cycle then closes out the frame bookkeeping,
    // which places frame_done exactly one edge behind the digit update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_cap  = 1'b0;
        case (state_q)
            SETTLE: begin
                if (sample_chg) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST - 8'd1) begin
                    cnt_d   = CNT_LAST;
                    state_d = CAPTURE;
                    do_cap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CAPTURE: begin
                cnt_d   = 8'd0;
                state_d = sample_chg ? SETTLE : HELD;
            end
            HELD: begin
                if (sample_chg) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        bad_d    = bad_q;
        seen_d   = seen_q;
        multi_d  = multi_q;
        frame_d  = 1'b0;
        // The mask is cleared the cycle after it fills, so all-ones here always
        // means the capture just completed a frame.
        if (state_q == CAPTURE && seen_q == 8'hFF) begin
            frame_d = 1'b1;
            seen_d  = 8'h00;
        end
        if (do_cap) begin
            if (an_act != 8'h00 && (an_act & 8'(an_act - 8'd1)) == 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (an_act[k]) begin
                        dp_d[k]   = dp_lit;
                        seen_d[k] = 1'b1;
                        if (dec[4]) begin
                            digits_d[4*k +: 4] = dec[3:0];
                            valid_d[k]         = 1'b1;
                            bad_d[k]           = 1'b0;
                        end else begin
                            valid_d[k] = 1'b0;
                            bad_d[k]   = (seg_act != 7'h00);
                        end
                    end
                end
            end else if (an_act != 8'h00) begin
                multi_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SETTLE;
            cnt_q    <= 8'd0;
            digits_q <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            bad_q    <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            bad_q    <= bad_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            multi_q  <= multi_d;
        end
    end

    assign digits          = digits_q;
    assign dp_out          = dp_q;
    assign digit_valid     = valid_q;
    assign bad_pattern     = bad_q;
    assign frame_done      = frame_q;
    assign multi_anode_err = multi_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture (STABLE_CYCLES=4).
// Inputs change 1 time unit after a rising edge; outputs are read at the same offset.
// frame_done pulses are tallied on the falling edge.
module tb_seg_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [31:0] digits;
    logic [7:0]  dp_out;
    logic [7:0]  digit_valid;
    logic [7:0]  bad_pattern;
    logic        frame_done;
    logic        multi_anode_err;

    int checks   = 0;
    int failures = 0;
    int fd_count = 0;

    // Lit-segment codes (gfedcba) for hex 0..F.
    logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .an_n            (an_n),
        .seg_n           (seg_n),
        .dp_n            (dp_n),
        .digits          (digits),
        .dp_out          (dp_out),
        .digit_valid     (digit_valid),
        .bad_pattern     (bad_pattern),
        .frame_done      (frame_done),
        .multi_anode_err (multi_anode_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        an_n  = 8'hFF;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
    endtask

    task automatic scan_digit(input int k, input logic [3:0] v);
        an_n  = ~(8'h01 << k);
        seg_n = ~SEG[v];
        dp_n  = 1'b1;
        cycles(10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        cycles(3);
        checks++; if (digits !== 32'h0) begin failures++; $display("FAIL reset_digits got=%h want=%h", digits, 32'h0); end
        checks++; if (dp_out !== 8'h00) begin failures++; $display("FAIL reset_dp got=%h want=%h", dp_out, 8'h00); end
        checks++; if (digit_valid !== 8'h00) begin failures++; $display("FAIL reset_valid got=%h want=%h", digit_valid, 8'h00); end
        checks++; if (bad_pattern !== 8'h00) begin failures++; $display("FAIL reset_bad got=%h want=%h", bad_pattern, 8'h00); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b want=0", frame_done); end
        checks++; if (multi_anode_err !== 1'b0) begin failures++; $display("FAIL reset_multi got=%b want=0", multi_anode_err); end
        rst_n = 1'b1;
        cycles(10);
    endtask

    // Digit 0 shows "3." ; update must land exactly on edge 6.
    task automatic test_latency();
        int base;
        base  = fd_count;
        an_n  = 8'hFE;
        seg_n = ~7'h4F;
        dp_n  = 1'b0;
        cycles(5);
        checks++; if (digit_valid !== 8'h00) begin failures++; $display("FAIL lat_early got=%h want=%h", digit_valid, 8'h00); end
        cycles(1);
        checks++; if (digits[3:0] !== 4'h3) begin failures++; $display("FAIL lat_digit got=%h want=%h", digits[3:0], 4'h3); end
        checks++; if (digit_valid !== 8'h01) begin failures++; $display("FAIL lat_valid got=%h want=%h", digit_valid, 8'h01); end
        checks++; if (dp_out !== 8'h01) begin failures++; $display("FAIL lat_dp got=%h want=%h", dp_out, 8'h01); end
        cycles(3);
        checks++; if (fd_count !== base) begin failures++; $display("FAIL lat_noframe got=%0d want=%0d", fd_count, base); end
        idle();
        cycles(10);
    endtask

    task automatic test_scan();
        int base;
        base = fd_count;
        for (int k = 0; k < 7; k++) scan_digit(k, 4'(k));
        checks++; if (fd_count !== base) begin failures++; $display("FAIL scan_early_frame got=%0d want=%0d", fd_count, base); end
        scan_digit(7, 4'h7);
        checks++; if (fd_count !== base + 1) begin failures++; $display("FAIL scan_frame got=%0d want=%0d", fd_count, base + 1); end
        checks++; if (digits !== 32'h76543210) begin failures++; $display("FAIL scan_digits got=%h want=%h", digits, 32'h76543210); end
        checks++; if (digit_valid !== 8'hFF) begin failures++; $display("FAIL scan_valid got=%h want=%h", digit_valid, 8'hFF); end
        checks++; if (dp_out !== 8'h00) begin failures++; $display("FAIL scan_dp got=%h want=%h", dp_out, 8'h00); end
        idle();
        cycles(10);
        scan_digit(7, 4'h7);
        idle();
        cycles(10);
        checks++; if (fd_count !== base + 1) begin failures++; $display("FAIL rescan_frame got=%0d want=%0d", fd_count, base + 1); end
    endtask

    task automatic test_glitch();
        an_n  = 8'hFD;
        seg_n = ~SEG[8];
        dp_n  = 1'b0;
        cycles(3);
        idle();
        cycles(12);
        checks++; if (digits !== 32'h76543210) begin failures++; $display("FAIL glitch_digits got=%h want=%h", digits, 32'h76543210); end
        checks++; if (dp_out !== 8'h00) begin failures++; $display("FAIL glitch_dp got=%h want=%h", dp_out, 8'h00); end
    endtask

    task automatic test_multi();
        an_n  = 8'hFC;
        seg_n = ~SEG[0];
        dp_n  = 1'b0;
        cycles(10);
        checks++; if (multi_anode_err !== 1'b1) begin failures++; $display("FAIL multi_set got=%b want=1", multi_anode_err); end
        checks++; if (digits !== 32'h76543210) begin failures++; $display("FAIL multi_digits got=%h want=%h", digits, 32'h76543210); end
        idle();
        cycles(10);
        checks++; if (multi_anode_err !== 1'b1) begin failures++; $display("FAIL multi_sticky got=%b want=1", multi_anode_err); end
    endtask

    task automatic test_bad_blank();
        an_n  = 8'hF7;
        seg_n = ~7'h55;
        dp_n  = 1'b1;
        cycles(10);
        checks++; if (bad_pattern !== 8'h08) begin failures++; $display("FAIL bad_set got=%h want=%h", bad_pattern, 8'h08); end
        checks++; if (digit_valid !== 8'hF7) begin failures++; $display("FAIL bad_valid got=%h want=%h", digit_valid, 8'hF7); end
        checks++; if (digits[15:12] !== 4'h3) begin failures++; $display("FAIL bad_digit got=%h want=%h", digits[15:12], 4'h3); end
        seg_n = ~7'h7F;
        cycles(10);
        checks++; if (bad_pattern !== 8'h00) begin failures++; $display("FAIL bad_clear got=%h want=%h", bad_pattern, 8'h00); end
        checks++; if (digits[15:12] !== 4'h8) begin failures++; $display("FAIL bad_fix_digit got=%h want=%h", digits[15:12], 4'h8); end
        // Blank digit 4 with its decimal point lit.
        an_n  = 8'hEF;
        seg_n = 7'h7F;
        dp_n  = 1'b0;
        cycles(10);
        checks++; if (digit_valid !== 8'hEF) begin failures++; $display("FAIL blank_valid got=%h want=%h", digit_valid, 8'hEF); end
        checks++; if (bad_pattern !== 8'h00) begin failures++; $display("FAIL blank_bad got=%h want=%h", bad_pattern, 8'h00); end
        checks++; if (digits !== 32'h76548210) begin failures++; $display("FAIL blank_digits got=%h want=%h", digits, 32'h76548210); end
        checks++; if (dp_out !== 8'h10) begin failures++; $display("FAIL blank_dp got=%h want=%h", dp_out, 8'h10); end
        idle();
        cycles(10);
    endtask

    task automatic test_reset_mid_frame();
        int base;
        for (int k = 0; k < 6; k++) scan_digit(k, 4'(k + 1));
        an_n  = 8'hBF;
        seg_n = ~SEG[2];
        cycles(2);
        rst_n = 1'b0;
        idle();
        cycles(3);
        checks++; if (digits !== 32'h0) begin failures++; $display("FAIL rst_mid_digits got=%h want=%h", digits, 32'h0); end
        checks++; if (multi_anode_err !== 1'b0) begin failures++; $display("FAIL rst_mid_multi got=%b want=0", multi_anode_err); end
        checks++; if (digit_valid !== 8'h00) begin failures++; $display("FAIL rst_mid_valid got=%h want=%h", digit_valid, 8'h00); end
        rst_n = 1'b1;
        base  = fd_count;
        cycles(10);
        checks++; if (fd_count !== base) begin failures++; $display("FAIL rst_release_frame got=%0d want=%0d", fd_count, base); end
        for (int k = 0; k < 7; k++) scan_digit(k, 4'(k + 8));
        checks++; if (fd_count !== base) begin failures++; $display("FAIL rst_partial_frame got=%0d want=%0d", fd_count, base); end
        scan_digit(7, 4'hF);
        idle();
        cycles(10);
        checks++; if (fd_count !== base + 1) begin failures++; $display("FAIL rst_full_frame got=%0d want=%0d", fd_count, base + 1); end
        checks++; if (digits !== 32'hFEDCBA98) begin failures++; $display("FAIL rst_scan_digits got=%h want=%h", digits, 32'hFEDCBA98); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_latency();
        test_scan();
        test_glitch();
        test_multi();
        test_bad_blank();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, sets the consecutive identical synchronized samples needed before capture; legal range 2..255.
REQ-002 clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 an_n  input  8  digit anodes, active-low; bit k selects digit k.
REQ-005 seg_n  input  7  cathodes, active-low; bit0=a ... bit6=g.
REQ-006 dp_n  input  1  decimal-point cathode, active-low.
REQ-007 digits  output  32  decoded nibbles; digit k occupies bits [4k+3:4k].
REQ-008 dp_out  output  8  dp_out[k] is 1 when digit k's last capture had its decimal point lit.
REQ-009 digit_valid  output  8  digit k's last capture was a legal hex pattern.
REQ-010 bad_pattern  output  8  digit k's last capture was neither hex nor blank.
REQ-011 frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the previous pulse.
REQ-012 multi_anode_err  output  1  sticky; set when a stable sample has more than one anode low.

Function
REQ-013 an_n, seg_n and dp_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 A 16-bit sample {an_n, dp_n, seg_n} SHALL be compared against the previous synchronized sample every cycle.
REQ-015 The FSM SHALL have exactly three states: SETTLE, CAPTURE and HELD.
REQ-016 SETTLE: the counter increments while the sample is unchanged and clears to 0 on any change; SETTLE moves to CAPTURE when the counter reaches STABLE_CYCLES-1.
REQ-017 CAPTURE lasts one cycle, performs the capture described in REQ-019 to REQ-022, then moves to HELD.
REQ-018 HELD: no capture occurs; any sample change moves to SETTLE with the counter at 0.
REQ-019 Capture with exactly one anode k low SHALL write all of digit k's fields; no other digit's fields change.
REQ-020 Hex decode table, lit segments gfedcba active-high:
  0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - On a match: digits[k]=value, digit_valid[k]=1, bad_pattern[k]=0.
REQ-021 Pattern 00 (blank): digit_valid[k]=0, bad_pattern[k]=0, digits[k] unchanged.
REQ-022 Any other pattern: digit_valid[k]=0, bad_pattern[k]=1, digits[k] unchanged.
REQ-023 On every capture of digit k, dp_out[k] SHALL be set to ~dp_n.
REQ-024 A capture with all anodes high SHALL change no output.
REQ-025 A capture with two or more anodes low SHALL change no digit field and SHALL set multi_anode_err.
REQ-026 Each digit capture (hex, blank or bad) SHALL set bit k of an internal 8-bit seen mask.
REQ-027 When a capture makes the seen mask all-ones: frame_done=1 on the next cycle and the mask is cleared in the same cycle.
REQ-028 A repeat capture of an already-seen digit SHALL neither pulse frame_done nor clear the mask.
REQ-029 Latency: a pin change held constant produces its output update 2+STABLE_CYCLES rising edges after the change; frame_done follows one cycle later.
REQ-030 Glitches shorter than STABLE_CYCLES synchronized cycles SHALL produce no capture.

Reset
REQ-031 While rst_n=0 at a rising edge, the following SHALL be cleared:
  - digits=0, dp_out=0, digit_valid=0, bad_pattern=0;
  - frame_done=0, multi_anode_err=0;
  - seen mask=0, counter=0, state=SETTLE.
REQ-032 During reset, both synchronizer stages and the previous-sample register SHALL load all-ones.
REQ-033 Reset asserted mid-SETTLE or mid-frame SHALL discard the partial count and the seen mask; no frame_done follows reset release.

Verification
REQ-034 STABLE_CYCLES=4; drive an_n=FE, seg_n=~4F, dp_n=0 -> digits[3:0]=3, digit_valid[0]=1, dp_out[0]=1, update on edge 6 after the change.
REQ-035 Scan digits 0..7 with patterns 0..7, each held 10 cycles -> digits=32'h76543210 and exactly one frame_done pulse after digit 7; rescanning digit 7 alone gives no pulse.
REQ-036 an_n=FD held 3 cycles (shorter than the stable window), then FF -> no output change.
REQ-037 an_n=FC stable -> multi_anode_err=1 and digits unchanged; it stays 1 until rst_n=0.
REQ-038 an_n=F7 with seg_n=~55 -> bad_pattern[3]=1, digit_valid[3]=0, digits[15:12] unchanged; a following 7F pattern on the same digit clears bad_pattern[3] and writes 8.
REQ-039 Assert rst_n=0 after digits 0..5 have been captured, then release and scan all 8 digits -> exactly one frame_done, only after the full post-reset scan.
